// File: rtl/mux_bank_211_414_811_if.sv
// Bus bundle for the 2:1 / 4:1-lane / 8:1 selector bank.
// The master drives data and selects; the slave returns the registered picks.
interface mux_bank_211_414_811_if #(
  parameter int unsigned LANE_W = 4
);
  logic [1:0]          inData211;
  logic                inSel211;
  logic                outData211;
  logic [4*LANE_W-1:0] inData414;
  logic [1:0]          inSel414;
  logic [LANE_W-1:0]   outData414;
  logic [7:0]          inData811;
  logic [2:0]          inSel811;
  logic                outData811;

  modport master (
    output inData211, inSel211, inData414, inSel414, inData811, inSel811,
    input  outData211, outData414, outData811
  );

  modport slave (
    input  inData211, inSel211, inData414, inSel414, inData811, inSel811,
    output outData211, outData414, outData811
  );
endinterface

// File: rtl/mux_bank_211_414_811.sv
// Three independent registered selectors: 2:1 bit, 4:1 of LANE_W-bit lanes, 8:1 bit.
// One cycle of latency; async reset loads RST_VAL into every output bit.
module mux_bank_211_414_811 #(
  parameter int unsigned LANE_W  = 4,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic                    inClk,
  input  logic                    inRst,
  mux_bank_211_414_811_if.slave   bus
);
  logic              pick211_c;
  logic [LANE_W-1:0] pick414_c;
  logic              pick811_c;

  // Combinational picks; every select code maps to a valid bit or lane.
  always_comb begin
    pick211_c = bus.inData211[bus.inSel211];
    pick811_c = bus.inData811[bus.inSel811];
    pick414_c = bus.inData414[0*LANE_W +: LANE_W];
    case (bus.inSel414)
      2'd0:    pick414_c = bus.inData414[0*LANE_W +: LANE_W];
      2'd1:    pick414_c = bus.inData414[1*LANE_W +: LANE_W];
      2'd2:    pick414_c = bus.inData414[2*LANE_W +: LANE_W];
      2'd3:    pick414_c = bus.inData414[3*LANE_W +: LANE_W];
      default: pick414_c = {LANE_W{1'bx}};
    endcase
  end

  always_ff @(posedge inClk or posedge inRst) begin
    if (inRst) begin
      bus.outData211 <= RST_VAL;
      bus.outData414 <= {LANE_W{RST_VAL}};
      bus.outData811 <= RST_VAL;
    end else begin
      bus.outData211 <= pick211_c;
      bus.outData414 <= pick414_c;
      bus.outData811 <= pick811_c;
    end
  end
endmodule

// File: tb/tb_mux_bank_211_414_811.sv
// Self-checking bench for mux_bank_211_414_811: directed table, reset corners,
// select sweep and random stimulus against a shift-and-mask reference.
module tb_mux_bank_211_414_811;
  localparam int unsigned LANE_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  mux_bank_211_414_811_if #(.LANE_W(LANE_W)) bus ();

  mux_bank_211_414_811 #(.LANE_W(LANE_W), .RST_VAL(1'b0)) dut (
    .inClk(clk),
    .inRst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  d211;
    logic        s211;
    logic [15:0] d414;
    logic [1:0]  s414;
    logic [7:0]  d811;
    logic [2:0]  s811;
    logic        e211;
    logic [3:0]  e414;
    logic        e811;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: selected bit/lane obtained by shifting the data right.
  function automatic logic [31:0] ref_bit(input logic [31:0] d, input int i);
    return (d >> i) & 32'd1;
  endfunction

  function automatic logic [31:0] ref_lane(input logic [31:0] d, input int i);
    return (d >> (i * LANE_W)) & ((32'd1 << LANE_W) - 32'd1);
  endfunction

  task automatic drive(input logic [1:0] d211, input logic s211, input logic [15:0] d414,
                       input logic [1:0] s414, input logic [7:0] d811, input logic [2:0] s811);
    bus.inData211 = d211; bus.inSel211 = s211;
    bus.inData414 = d414; bus.inSel414 = s414;
    bus.inData811 = d811; bus.inSel811 = s811;
  endtask

  task automatic scramble();
    drive(2'($urandom), 1'($urandom), 16'($urandom), 2'($urandom), 8'($urandom), 3'($urandom));
  endtask

  task automatic check_outs(input string name, input logic [31:0] e211,
                            input logic [31:0] e414, input logic [31:0] e811);
    check({name, ".211"}, 32'(bus.outData211), e211);
    check({name, ".414"}, 32'(bus.outData414), e414);
    check({name, ".811"}, 32'(bus.outData811), e811);
  endtask

  // Clock once, then disturb inputs so a non-registered output would show up.
  task automatic edge_check(input string name, input logic [31:0] e211,
                            input logic [31:0] e414, input logic [31:0] e811);
    @(posedge clk);
    #1;
    scramble();
    #1;
    check_outs(name, e211, e414, e811);
  endtask

  task automatic model_step(input string name);
    logic [31:0] e211, e414, e811;
    e211 = ref_bit(32'(bus.inData211), int'(bus.inSel211));
    e414 = ref_lane(32'(bus.inData414), int'(bus.inSel414));
    e811 = ref_bit(32'(bus.inData811), int'(bus.inSel811));
    edge_check(name, e211, e414, e811);
  endtask

  initial begin
    vecs[0] = '{2'b10, 1'b0, 16'h00B0, 2'b01, 8'h0B, 3'd0, 1'b0, 4'hB, 1'b1};
    vecs[1] = '{2'b10, 1'b1, 16'h00B0, 2'b00, 8'h0B, 3'd1, 1'b1, 4'h0, 1'b1};
    vecs[2] = '{2'b01, 1'b0, 16'hF000, 2'b11, 8'h0B, 3'd2, 1'b1, 4'hF, 1'b0};
    vecs[3] = '{2'b01, 1'b1, 16'hF000, 2'b10, 8'h0B, 3'd3, 1'b0, 4'h0, 1'b1};
    vecs[4] = '{2'b11, 1'b0, 16'h1234, 2'b00, 8'h80, 3'd7, 1'b1, 4'h4, 1'b1};
    vecs[5] = '{2'b00, 1'b1, 16'h1234, 2'b10, 8'h80, 3'd6, 1'b0, 4'h2, 1'b0};

    // Reset asserted before any clock edge clears outputs immediately.
    scramble();
    #1 rst = 1'b1;
    #1 check_outs("rst_noedge", 0, 0, 0);
    @(posedge clk);
    #1 check_outs("rst_hold", 0, 0, 0);
    #1 rst = 1'b0;
    drive(2'b10, 1'b1, 16'h0F00, 2'd2, 8'h40, 3'd6);
    edge_check("rst_release", 1, 4'hF, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].d211, vecs[i].s211, vecs[i].d414, vecs[i].s414, vecs[i].d811, vecs[i].s811);
      edge_check($sformatf("vec%0d", i), 32'(vecs[i].e211), 32'(vecs[i].e414), 32'(vecs[i].e811));
    end

    // Mid-run reset between edges drops ones to zero at once.
    drive(2'b11, 1'b0, 16'hF0F0, 2'd3, 8'hFF, 3'd4);
    edge_check("pre_midrst", 1, 4'hF, 1);
    rst = 1'b1;
    #1 check_outs("midrst_now", 0, 0, 0);
    drive(2'b11, 1'b1, 16'hFFFF, 2'd1, 8'hFF, 3'd5);
    @(posedge clk);
    #1 check_outs("midrst_hold", 0, 0, 0);
    #1 rst = 1'b0;
    drive(2'b01, 1'b0, 16'h0A00, 2'd2, 8'h04, 3'd2);
    edge_check("midrst_resume", 1, 4'hA, 1);

    // Sweep: each select held four cycles while data advances every cycle.
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 4; c++) begin
        int k;
        k = p * 4 + c;
        drive(2'(k), 1'(p), 16'(k * 16'h1357), 2'(p), 8'(k * 37), 3'(p));
        model_step($sformatf("sweep%0d", k));
      end
    end

    for (int n = 0; n < 150; n++) begin
      scramble();
      model_step($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
